// File: rtl/rng_scheduler.sv
// rng_scheduler: round-robin arbiter that shares one LFSR random source
// between NUM_REQ game engines and reduces each draw to [0, limit) by
// masked rejection sampling with a bounded retry count and a fallback.
//
// Ports:
//   clk_i          system clock
//   reset_ni       asynchronous active-low reset
//   req_i          per-requester request level
//   limit_i        per-requester exclusive upper bound, WIDTH bits each;
//                  slice i = limit_i[i*WIDTH +: WIDTH], 0 means 2^WIDTH
//   ack_o          one-hot, one-cycle pulse; rnd_data_o valid for that requester
//   rnd_data_o     drawn value, held until the next ack
//   busy_o         high whenever a draw is in progress
//   lfsr_enable_o  step enable to the LFSR
//   lfsr_out_i     LFSR mixed output
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; LFSR free-runs when FREE_RUN != 0
// STIR    | LFSR stepped for STIR_CYCLES consecutive cycles
// CHECK   | masked candidate accepted, retried, or reduced by fallback
// DELIVER | ack pulse and result registered; pointer advances

module rng_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 9,
  parameter int STIR_CYCLES = 3,
  parameter int MAX_RETRY   = 8,
  parameter int FREE_RUN    = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] limit_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]         rnd_data_o,
  output logic                     busy_o,
  output logic                     lfsr_enable_o,
  input  logic [WIDTH-1:0]         lfsr_out_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, STIR, CHECK, DELIVER} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WIDTH:0]     lim_q, lim_d;     // one extra bit so 2^WIDTH fits
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [3:0]         retry_q, retry_d;
  logic [3:0]         stir_q, stir_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   rnd_q, rnd_d;

  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic [WIDTH-1:0]   lim_raw;
  logic [WIDTH-1:0]   lim_m1;
  logic [WIDTH-1:0]   mask_g;
  logic [WIDTH:0]     lim_full;
  logic [WIDTH-1:0]   cand;
  logic               cand_ok;
  logic               lfsr_en;

  // Round-robin pick: scan distances from the pointer in descending order so
  // the nearest set request (distance 0 = pointer itself) is written last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_i[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          grant_found = 1'b1;
          grant_idx   = IW'(i);
        end
      end
    end
  end

  // Limit of the winner and its rejection mask. lim-1 wraps 0 -> all ones,
  // which is exactly the mask wanted for lim = 2^WIDTH; smearing lim-1 to
  // the right gives (next power of two >= lim) - 1.
  always_comb begin
    lim_raw = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) lim_raw = limit_i[i*WIDTH +: WIDTH];
    end
    lim_m1 = lim_raw - WIDTH'(1);
    mask_g = lim_m1;
    for (int j = 1; j < WIDTH; j++) mask_g = mask_g | (lim_m1 >> j);
    lim_full = (lim_raw == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, lim_raw};
  end

  assign cand    = lfsr_out_i & mask_q;
  assign cand_ok = {1'b0, cand} < lim_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    stir_d  = stir_q;
    ack_d   = '0;
    rnd_d   = rnd_q;
    lfsr_en = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_en = (FREE_RUN != 0);
        if (grant_found) begin
          idx_d   = grant_idx;
          lim_d   = lim_full;
          mask_d  = mask_g;
          retry_d = '0;
          stir_d  = 4'(STIR_CYCLES);
          state_d = STIR;
        end
      end
      STIR: begin
        lfsr_en = 1'b1;
        stir_d  = stir_q - 4'd1;
        if (stir_q == 4'd1) state_d = CHECK;
      end
      CHECK: begin
        if (cand_ok) begin
          rnd_d   = cand;
          ack_d   = NUM_REQ'(1) << idx_q;
          state_d = DELIVER;
        end else if (retry_q == 4'(MAX_RETRY - 1)) begin
          // mask < 2*lim, so cand - lim is already in range
          rnd_d   = cand - lim_q[WIDTH-1:0];
          ack_d   = NUM_REQ'(1) << idx_q;
          state_d = DELIVER;
        end else begin
          retry_d = retry_q + 4'd1;
          stir_d  = 4'(STIR_CYCLES);
          state_d = STIR;
        end
      end
      DELIVER: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      retry_q <= '0;
      stir_q  <= '0;
      ack_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      stir_q  <= stir_d;
      ack_q   <= ack_d;
      rnd_q   <= rnd_d;
    end
  end

  assign ack_o         = ack_q;
  assign rnd_data_o    = rnd_q;
  assign busy_o        = (state_q != IDLE);
  assign lfsr_enable_o = lfsr_en;

endmodule
